rv_mem_target: RTL

Downstream target for the round-robin request/response arbiter: it consumes the arbiter's single 16-bit ready/valid request stream and returns exactly one 16-bit response per request, strictly in order, on the matching response stream. It contains a 128x8 register-file memory, a fixed-latency read pipeline and a response FIFO. A credit counter bounds in-flight transactions, so the response path never drops data while the arbiter's response-routing FIFO is waiting.

---
 rtl/rv_mem_target.sv | 169 ++++++++++++++++
 1 files changed

// File: rtl/rv_mem_target.sv
// rtl/rv_mem_target.sv - memory target with fixed-latency reads, response FIFO and credit flow control
//
// Consumes one 16-bit request per cycle and returns one 16-bit response per
// request, in acceptance order.
//
// Parameters:
//   LATENCY         cycles from request acceptance to the earliest response_valid (1..4)
//   RSP_FIFO_DEPTH  response FIFO entries, also the in-flight request limit (LATENCY..8)
//
// Ports:
//   clk             clock; all state updates on the rising edge
//   rst             asynchronous active-low reset, synchronous release
//   request_data    [15] write flag, [14:8] address, [7:0] write data
//   request_valid   request present
//   request_ready   target can accept (credits available)
//   response_data   [15] write flag, [14:8] address, [7:0] data
//   response_valid  FIFO head valid
//   response_ready  consumer takes the head
//   outstanding     accepted requests not yet popped
module rv_mem_target #(
  parameter int LATENCY        = 2,
  parameter int RSP_FIFO_DEPTH = 4,
  localparam int CNT_W         = $clog2(RSP_FIFO_DEPTH + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [15:0]      request_data,
  input  logic             request_valid,
  output logic             request_ready,
  output logic [15:0]      response_data,
  output logic             response_valid,
  input  logic             response_ready,
  output logic [CNT_W-1:0] outstanding
);

  localparam int PTR_W = (RSP_FIFO_DEPTH > 1) ? $clog2(RSP_FIFO_DEPTH) : 1;
  localparam logic [CNT_W-1:0] FULL_CREDITS = CNT_W'(RSP_FIFO_DEPTH);
  localparam logic [PTR_W-1:0] LAST_PTR     = PTR_W'(RSP_FIFO_DEPTH - 1);

  logic             accept;
  logic             pop;
  logic             req_wr;
  logic [6:0]       req_addr;
  logic [7:0]       req_wdata;
  logic [15:0]      rsp_word;
  logic             push_valid;
  logic [15:0]      push_data;
  logic [CNT_W-1:0] credits;

  logic [7:0]       mem [128];

  logic [15:0]      fifo_mem [RSP_FIFO_DEPTH];
  logic [PTR_W-1:0] head;
  logic [PTR_W-1:0] tail;
  logic [CNT_W-1:0] count;

  assign req_wr    = request_data[15];
  assign req_addr  = request_data[14:8];
  assign req_wdata = request_data[7:0];

  // request_ready is state-only; rst forces it low while reset is held.
  assign request_ready = rst & (credits != '0);
  assign accept        = request_valid & request_ready;

  assign response_valid = (count != '0);
  assign pop            = response_valid & response_ready;
  // Masking with valid keeps the output at zero while empty or in reset.
  assign response_data  = response_valid ? fifo_mem[head] : '0;

  assign outstanding = FULL_CREDITS - credits;

  // Memory is intentionally not reset so contents survive a mid-operation reset.
  always_ff @(posedge clk) begin
    if (accept && req_wr) begin
      mem[req_addr] <= req_wdata;
    end
  end

  // Combinational read sees the value before this edge's write lands, which is
  // the value present at the accepting edge. Writes echo their own data.
  assign rsp_word = {req_wr, req_addr, req_wr ? req_wdata : mem[req_addr]};

  // LATENCY-1 register stages; the FIFO write is the final register, so with
  // LATENCY=1 the response goes straight into the FIFO at the accepting edge.
  generate
    if (LATENCY == 1) begin : g_no_pipe
      assign push_valid = accept;
      assign push_data  = rsp_word;
    end else begin : g_pipe
      logic [LATENCY-2:0] pipe_valid;
      logic [15:0]        pipe_data [LATENCY-1];

      always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
          pipe_valid <= '0;
        end else begin
          pipe_valid[0] <= accept;
          for (int i = 1; i < LATENCY - 1; i++) begin
            pipe_valid[i] <= pipe_valid[i-1];
          end
        end
      end

      // Data stages only matter when their valid is set.
      always_ff @(posedge clk) begin
        pipe_data[0] <= rsp_word;
        for (int i = 1; i < LATENCY - 1; i++) begin
          pipe_data[i] <= pipe_data[i-1];
        end
      end

      assign push_valid = pipe_valid[LATENCY-2];
      assign push_data  = pipe_data[LATENCY-2];
    end
  endgenerate

  function automatic logic [PTR_W-1:0] next_ptr(input logic [PTR_W-1:0] p);
    next_ptr = (p == LAST_PTR) ? '0 : p + PTR_W'(1);
  endfunction

  always_ff @(posedge clk) begin
    if (push_valid) begin
      fifo_mem[tail] <= push_data;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
    end else begin
      if (push_valid) begin
        tail <= next_ptr(tail);
      end
      if (pop) begin
        head <= next_ptr(head);
      end
      case ({push_valid, pop})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
    end
  end

  // One credit per in-flight request; returned when its response is popped.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      credits <= FULL_CREDITS;
    end else begin
      case ({accept, pop})
        2'b10:   credits <= credits - CNT_W'(1);
        2'b01:   credits <= credits + CNT_W'(1);
        default: credits <= credits;
      endcase
    end
  end

  a_credit_underflow: assert property (@(posedge clk) disable iff (!rst)
    !(accept && !pop && credits == '0));
  a_credit_overflow: assert property (@(posedge clk) disable iff (!rst)
    !(pop && !accept && credits == FULL_CREDITS));
  a_credit_range: assert property (@(posedge clk) disable iff (!rst)
    credits <= FULL_CREDITS);
  a_fifo_overflow: assert property (@(posedge clk) disable iff (!rst)
    !(push_valid && !pop && count == FULL_CREDITS));

endmodule
